// File: rtl/fifo_access_sched.sv
// Arbitrates NREQ writers and one reader onto a single FIFO, never pushing and popping together.
// Optional per-writer starvation watchdog enabled by defining FIFO_SCHED_WDOG_EN.
module fifo_access_sched #(
   parameter int DW     = 8,
   parameter int NREQ   = 4,
   parameter int STARVE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      wr_req,
   input  logic [NREQ*DW-1:0]   wr_data,
   output logic [NREQ-1:0]      wr_gnt,
   input  logic                 rd_req,
   output logic                 rd_gnt,
   output logic [DW-1:0]        rd_data,
   output logic                 fifo_push,
   output logic                 fifo_pop,
   output logic [DW-1:0]        fifo_data_wr,
   input  logic [DW-1:0]        fifo_data_rd,
   input  logic                 fifo_full,
   input  logic                 fifo_empty
`ifdef FIFO_SCHED_WDOG_EN
   ,
   output logic                 starve_err
`endif
);

   localparam int   PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic LAST_WR = 1'b0;
   localparam logic LAST_RD = 1'b1;

   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic          last_op_q, last_op_d;
   logic [PW-1:0] pick;
   logic          found;
   logic          wr_cand, rd_cand;
   logic          do_wr, do_rd;
   int            idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      // Rotating search starting at rr_ptr; index folded back into 0..NREQ-1.
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && wr_req[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end

      wr_cand = found & ~fifo_full;
      rd_cand = rd_req & ~fifo_empty;
      // On a tie the operation not performed last time wins.
      do_wr   = ~rst & wr_cand & (~rd_cand | (last_op_q == LAST_RD));
      do_rd   = ~rst & rd_cand & (~wr_cand | (last_op_q == LAST_WR));

      rr_ptr_d  = rr_ptr_q;
      last_op_d = last_op_q;
      if (do_wr) begin
         rr_ptr_d  = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
         last_op_d = LAST_WR;
      end else if (do_rd) begin
         last_op_d = LAST_RD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q  <= '0;
         last_op_q <= LAST_RD;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         last_op_q <= last_op_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_gnt
         assign wr_gnt[gi] = do_wr & (pick == PW'(gi));
      end
   endgenerate

   assign rd_gnt       = do_rd;
   assign fifo_push    = do_wr;
   assign fifo_pop     = do_rd;
   assign fifo_data_wr = do_wr ? wr_data[pick*DW +: DW] : '0;
   assign rd_data      = fifo_data_rd;

`ifdef FIFO_SCHED_WDOG_EN
   localparam int CW = $clog2(STARVE + 1);

   logic [CW-1:0]   wait_cnt_q [NREQ];
   logic [CW-1:0]   wait_cnt_d [NREQ];
   logic [NREQ-1:0] hit;
   logic            starve_err_q, starve_err_d;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         wait_cnt_d[i] = wait_cnt_q[i];
         if (!wr_req[i] || wr_gnt[i]) begin
            wait_cnt_d[i] = '0;
         end else if (!fifo_full && (wait_cnt_q[i] != CW'(STARVE))) begin
            wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
         end
         hit[i] = (wait_cnt_d[i] == CW'(STARVE));
      end
      starve_err_d = starve_err_q | (|hit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREQ; i++) wait_cnt_q[i] <= '0;
         starve_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREQ; i++) wait_cnt_q[i] <= wait_cnt_d[i];
         starve_err_q <= starve_err_d;
      end
   end

   assign starve_err = starve_err_q & ~rst;
`endif

endmodule

// File: tb/tb_fifo_access_sched.sv
// Directed table-driven bench for fifo_access_sched (NREQ=4) plus a NREQ=3 wrap sequence.
module tb_fifo_access_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // NREQ=4 instance
   logic        rst, rd_req, fifo_full, fifo_empty;
   logic [3:0]  wr_req, wr_gnt;
   logic [31:0] wr_data;
   logic        rd_gnt, fifo_push, fifo_pop;
   logic [7:0]  rd_data, fifo_data_wr, fifo_data_rd;
`ifdef FIFO_SCHED_WDOG_EN
   logic        starve_err, starve_err3;
`endif

   // NREQ=3 instance
   logic        rst3, rd_req3, fifo_full3, fifo_empty3;
   logic [2:0]  wr_req3, wr_gnt3;
   logic [23:0] wr_data3;
   logic        rd_gnt3, fifo_push3, fifo_pop3;
   logic [7:0]  rd_data3, fifo_data_wr3, fifo_data_rd3;

   fifo_access_sched #(.DW(8), .NREQ(4), .STARVE(16)) dut (
      .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_data(rd_data),
      .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_data_wr(fifo_data_wr),
      .fifo_data_rd(fifo_data_rd), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
`ifdef FIFO_SCHED_WDOG_EN
      , .starve_err(starve_err)
`endif
   );

   fifo_access_sched #(.DW(8), .NREQ(3), .STARVE(16)) dut3 (
      .clk(clk), .rst(rst3), .wr_req(wr_req3), .wr_data(wr_data3), .wr_gnt(wr_gnt3),
      .rd_req(rd_req3), .rd_gnt(rd_gnt3), .rd_data(rd_data3),
      .fifo_push(fifo_push3), .fifo_pop(fifo_pop3), .fifo_data_wr(fifo_data_wr3),
      .fifo_data_rd(fifo_data_rd3), .fifo_full(fifo_full3), .fifo_empty(fifo_empty3)
`ifdef FIFO_SCHED_WDOG_EN
      , .starve_err(starve_err3)
`endif
   );

   typedef struct {
      logic       rst;
      logic [3:0] wr;
      logic       rd;
      logic       full;
      logic       empty;
      logic [3:0] gnt;
      logic       rdg;
      logic       push;
      logic       pop;
      logic [7:0] dwr;
      string      name;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   initial begin
      logic [2:0] s_wr  [6];
      logic [2:0] s_gnt [6];
      logic [7:0] s_dat [6];

      //              rst  wr       rd   full empty gnt      rdg  push pop  dwr
      vecs[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, "rst_hold"};
      vecs[1]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 8'hA0, "rr_w0"};
      vecs[2]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 8'hA1, "rr_w1"};
      vecs[3]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 8'hA2, "rr_w2"};
      vecs[4]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 8'hA3, "rr_w3"};
      vecs[5]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 8'hA0, "rr_wrap"};
      vecs[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, "empty_rd_a"};
      vecs[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, "empty_rd_b"};
      vecs[8]  = '{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h00, "alt_rd1"};
      vecs[9]  = '{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 8'hA0, "alt_wr1"};
      vecs[10] = '{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h00, "alt_rd2"};
      vecs[11] = '{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 8'hA0, "alt_wr2"};
      vecs[12] = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h00, "full_rd1"};
      vecs[13] = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h00, "full_rd2"};
      vecs[14] = '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h00, "full_rd3"};
      vecs[15] = '{1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 8'hA2, "unfull_w2"};
      vecs[16] = '{1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 8'hA3, "skip_w3"};
      vecs[17] = '{1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 8'hA0, "skip_w0"};
      vecs[18] = '{1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 8'hA3, "skip_w3b"};
      vecs[19] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h00, "rd_only"};
      vecs[20] = '{1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 8'hA1, "tie_after_rd"};
      vecs[21] = '{1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, "mid_rst"};
      vecs[22] = '{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 8'hA0, "post_rst_tie"};
      vecs[23] = '{1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h00, "post_rst_rd"};
      vecs[24] = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, "full_idle"};

      s_wr  = '{3'b111, 3'b111, 3'b111, 3'b011, 3'b011, 3'b011};
      s_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b001};
      s_dat = '{8'h30,  8'h31,  8'h32,  8'h30,  8'h31,  8'h30};

      rst = 1'b1; wr_req = '0; rd_req = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
      wr_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      fifo_data_rd = 8'h5C;
      rst3 = 1'b1; wr_req3 = '0; rd_req3 = 1'b0; fifo_full3 = 1'b0; fifo_empty3 = 1'b1;
      wr_data3 = {8'h32, 8'h31, 8'h30};
      fifo_data_rd3 = 8'h00;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst        = vecs[i].rst;
         wr_req     = vecs[i].wr;
         rd_req     = vecs[i].rd;
         fifo_full  = vecs[i].full;
         fifo_empty = vecs[i].empty;
         #2;
         chk({vecs[i].name, ".wr_gnt"}, 32'(wr_gnt), 32'(vecs[i].gnt));
         chk({vecs[i].name, ".rd_gnt"}, 32'(rd_gnt), 32'(vecs[i].rdg));
         chk({vecs[i].name, ".push"},   32'(fifo_push), 32'(vecs[i].push));
         chk({vecs[i].name, ".pop"},    32'(fifo_pop), 32'(vecs[i].pop));
         chk({vecs[i].name, ".data_wr"}, 32'(fifo_data_wr), 32'(vecs[i].dwr));
         chk({vecs[i].name, ".push_pop_excl"}, 32'(fifo_push & fifo_pop), 32'd0);
         chk({vecs[i].name, ".gnt_onehot0"}, 32'($onehot0(wr_gnt)), 32'd1);
`ifdef FIFO_SCHED_WDOG_EN
         chk({vecs[i].name, ".starve_err"}, 32'(starve_err), 32'd0);
`endif
         $display("vec %0d %s: wr_gnt=%b rd_gnt=%b push=%b pop=%b data_wr=%h",
                  i, vecs[i].name, wr_gnt, rd_gnt, fifo_push, fifo_pop, fifo_data_wr);
      end

      // rd_data is a straight pass-through of the FIFO read port.
      fifo_data_rd = 8'hC3;
      #1;
      chk("rd_data_pass", 32'(rd_data), 32'hC3);
      $display("rd_data pass-through: rd_data=%h", rd_data);

      // NREQ=3 wrap: pointer goes 2 -> 0, then 011 alternates between writers 0 and 1.
      @(negedge clk);
      rst3 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wr_req3 = s_wr[i];
         #2;
         chk($sformatf("n3_step%0d.wr_gnt", i), 32'(wr_gnt3), 32'(s_gnt[i]));
         chk($sformatf("n3_step%0d.data_wr", i), 32'(fifo_data_wr3), 32'(s_dat[i]));
         chk($sformatf("n3_step%0d.push", i), 32'(fifo_push3), 32'd1);
         $display("n3 step %0d: wr_req=%b wr_gnt=%b data_wr=%h", i, wr_req3, wr_gnt3, fifo_data_wr3);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
